// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM driving the datapath selects, with a
// bounded wait on unified memory and a sticky fault code latched on entry to HALT.
module mc_control #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       instr_done,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] fault,
  output logic [2:0] ALUOp,
  output logic [3:0] state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    RESET_WAIT = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD      = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC_R = 4'd7,
    RWB        = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, JAL    = 4'd11,
    JR         = 4'd12, EXEC_I = 4'd13, IWB    = 4'd14, HALT   = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    fault_q, fault_d;
  logic [CW-1:0] wait_cnt;
  logic          waiting;

  // The branch condition is resolved in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;
  assign fault = fault_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RESET_WAIT;
      fault_q  <= 2'd0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    waiting       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    instr_done    = 1'b0;
    RegDst        = 2'd0;
    ALUSrcB       = 2'd0;
    PCSource      = 2'd0;
    ALUOp         = 3'b000;
    case (state_q)
      RESET_WAIT: state_d = FETCH;
      FETCH: begin
        waiting = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        case (opcode)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = (funct == 6'b001000) ? JR : EXEC_R;
          6'b000100, 6'b000101: state_d = BRANCH;
          6'b000010:            state_d = JUMP;
          6'b000011:            state_d = JAL;
          6'b001000, 6'b001100, 6'b001101,
          6'b001110, 6'b001010, 6'b001111: state_d = EXEC_I;
          default: begin
            state_d = HALT;
            fault_d = 2'd1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        state_d = (opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        waiting = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        waiting    = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        state_d = RWB;
      end
      RWB: begin
        RegDst     = 2'd1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b001;
        PCSource      = 2'd1;
        PCWriteCond   = (opcode == 6'b000100);
        PCWriteCondNe = (opcode == 6'b000101);
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'd2;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        PCWrite    = 1'b1;
        PCSource   = 2'd2;
        RegDst     = 2'd2;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JR: begin
        PCWrite    = 1'b1;
        PCSource   = 2'd3;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        case (opcode)
          6'b001100: ALUOp = 3'b011;
          6'b001101: ALUOp = 3'b100;
          6'b001110: ALUOp = 3'b101;
          6'b001010: ALUOp = 3'b110;
          6'b001111: ALUOp = 3'b111;
          default:   ALUOp = 3'b000;
        endcase
        state_d = IWB;
      end
      IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
    // A stalled access past the budget overrides whatever the state chose.
    if (waiting && !mem_ready && wait_cnt == CW'(TIMEOUT - 1)) begin
      state_d = HALT;
      fault_d = 2'd2;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed vector table, hand-written corner sequences,
// and random instruction streams checked against a per-instruction path model.
module tb_mc_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegWrite, ALUSrcA, instr_done;
  logic [1:0] RegDst, ALUSrcB, PCSource, fault;
  logic [2:0] ALUOp;
  logic [3:0] state;

  mc_control #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCWriteCondNe(PCWriteCondNe), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .instr_done(instr_done),
    .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .fault(fault),
    .ALUOp(ALUOp), .state(state)
  );

  always #5 clock = ~clock;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                 S_MEMWB = 5, S_MEMWR = 6, S_EXEC_R = 7, S_RWB = 8, S_BRANCH = 9,
                 S_JUMP = 10, S_JAL = 11, S_JR = 12, S_EXEC_I = 13, S_IWB = 14,
                 S_HALT = 15;

  // {PCWrite..instr_done, RegDst, ALUSrcB, PCSource, ALUOp}
  wire [19:0] ov = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
                    IRWrite, MemtoReg, RegWrite, ALUSrcA, instr_done,
                    RegDst, ALUSrcB, PCSource, ALUOp};

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // f = {PCWrite,PCWriteCond,PCWriteCondNe,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,instr_done}
  function automatic logic [19:0] mk(input logic [10:0] f, input logic [1:0] rd,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic [2:0] alu);
    return {f, rd, asb, pcs, alu};
  endfunction

  // ---------------- reference model ----------------
  int exp_st[$];
  bit exp_mr[$];

  // 0 lw, 1 sw, 2 R, 3 jr, 4 beq/bne, 5 j, 6 jal, 7 I-type, 8 illegal
  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return 0;
      6'h2b: return 1;
      6'h00: return (fn == 6'h08) ? 3 : 2;
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      6'h03: return 6;
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f: return 7;
      default: return 8;
    endcase
  endfunction

  function automatic void push(input int s);
    exp_st.push_back(s);
    exp_mr.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic void push_wait(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      exp_st.push_back(s);
      exp_mr.push_back(1'b0);
    end
    exp_st.push_back(s);
    exp_mr.push_back(1'b1);
  endfunction

  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input int fw, input int mw);
    exp_st.delete();
    exp_mr.delete();
    push_wait(S_FETCH, fw);
    push(S_DECODE);
    case (kind(op, fn))
      0: begin push(S_MEMADR); push_wait(S_MEMRD, mw); push(S_MEMWB); end
      1: begin push(S_MEMADR); push_wait(S_MEMWR, mw); end
      2: begin push(S_EXEC_R); push(S_RWB); end
      3: push(S_JR);
      4: push(S_BRANCH);
      5: push(S_JUMP);
      6: push(S_JAL);
      7: begin push(S_EXEC_I); push(S_IWB); end
      default: ;
    endcase
  endfunction

  // Runs one instruction cycle-by-cycle against the model; captures the
  // output vector at cycle ck and the observed latency to instr_done.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int ck, output int lat,
                           output logic [19:0] vk);
    int  k;
    bit  writes, jumps, last;
    build(op, fn, fw, mw);
    k      = kind(op, fn);
    writes = (k == 0 || k == 2 || k == 6 || k == 7);
    jumps  = (k == 3 || k == 5 || k == 6);
    lat    = 0;
    vk     = '0;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < exp_st.size(); i++) begin
      @(negedge clock);
      mem_ready = exp_mr[i];
      #1;
      last = (i == exp_st.size() - 1);
      if (instr_done === 1'b1 && lat == 0) lat = i + 1;
      if (i == ck) vk = ov;
      chk("state", state, exp_st[i]);
      chk("instr_done", instr_done, last);
      chk("RegWrite", RegWrite, writes && last);
      chk("MemWrite", MemWrite, k == 1 && exp_st[i] == S_MEMWR);
      chk("MemRead", MemRead, exp_st[i] == S_FETCH || exp_st[i] == S_MEMRD);
      chk("PCWrite", PCWrite, (exp_st[i] == S_FETCH && exp_mr[i]) || (jumps && last));
      chk("fault", fault, 0);
    end
  endtask

  task automatic step(input logic mr);
    @(negedge clock);
    mem_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_state", state, S_RST);
    chk("rst_outputs", ov, 0);
    chk("rst_fault", fault, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic expect_timeout(input int st);
    for (int i = 0; i < 16; i++) begin
      step(1'b0);
      chk("wait_state", state, st);
    end
    step(1'b0);
    chk("timeout_state", state, S_HALT);
    chk("timeout_fault", fault, 2);
  endtask

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    int         fw, mw, lat, ck;
    logic [19:0] ev;
  } vec_t;

  vec_t       tbl[18];
  logic [5:0] ops[14] = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03,
                          6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, idx;
    logic [19:0] v;
    logic [5:0] fn;

    tbl[0]  = '{"lw",       6'h23, 6'h00, 0, 0, 5, 4, mk(11'b00000001101, 2'd0, 2'd0, 2'd0, 3'd0)};
    tbl[1]  = '{"sw",       6'h2b, 6'h00, 0, 0, 4, 3, mk(11'b00010100001, 2'd0, 2'd0, 2'd0, 3'd0)};
    tbl[2]  = '{"sw_wait3", 6'h2b, 6'h00, 0, 3, 7, 6, mk(11'b00010100001, 2'd0, 2'd0, 2'd0, 3'd0)};
    tbl[3]  = '{"lw_wait",  6'h23, 6'h00, 2, 1, 8, 7, mk(11'b00000001101, 2'd0, 2'd0, 2'd0, 3'd0)};
    tbl[4]  = '{"add",      6'h00, 6'h20, 0, 0, 4, 3, mk(11'b00000000101, 2'd1, 2'd0, 2'd0, 3'd0)};
    tbl[5]  = '{"beq",      6'h04, 6'h00, 0, 0, 3, 2, mk(11'b01000000011, 2'd0, 2'd0, 2'd1, 3'd1)};
    tbl[6]  = '{"bne",      6'h05, 6'h00, 0, 0, 3, 2, mk(11'b00100000011, 2'd0, 2'd0, 2'd1, 3'd1)};
    tbl[7]  = '{"j",        6'h02, 6'h00, 0, 0, 3, 2, mk(11'b10000000001, 2'd0, 2'd0, 2'd2, 3'd0)};
    tbl[8]  = '{"jal",      6'h03, 6'h00, 0, 0, 3, 2, mk(11'b10000000101, 2'd2, 2'd0, 2'd2, 3'd0)};
    tbl[9]  = '{"jr",       6'h00, 6'h08, 0, 0, 3, 2, mk(11'b10000000001, 2'd0, 2'd0, 2'd3, 3'd0)};
    tbl[10] = '{"addi",     6'h08, 6'h00, 0, 0, 4, 2, mk(11'b00000000010, 2'd0, 2'd2, 2'd0, 3'd0)};
    tbl[11] = '{"andi",     6'h0c, 6'h00, 0, 0, 4, 2, mk(11'b00000000010, 2'd0, 2'd2, 2'd0, 3'd3)};
    tbl[12] = '{"ori",      6'h0d, 6'h00, 0, 0, 4, 2, mk(11'b00000000010, 2'd0, 2'd2, 2'd0, 3'd4)};
    tbl[13] = '{"xori",     6'h0e, 6'h00, 0, 0, 4, 2, mk(11'b00000000010, 2'd0, 2'd2, 2'd0, 3'd5)};
    tbl[14] = '{"slti",     6'h0a, 6'h00, 0, 0, 4, 2, mk(11'b00000000010, 2'd0, 2'd2, 2'd0, 3'd6)};
    tbl[15] = '{"lui",      6'h0f, 6'h00, 0, 0, 4, 2, mk(11'b00000000010, 2'd0, 2'd2, 2'd0, 3'd7)};
    tbl[16] = '{"fetch_st", 6'h08, 6'h00, 1, 0, 5, 0, mk(11'b00001000000, 2'd0, 2'd1, 2'd0, 3'd0)};
    tbl[17] = '{"decode",   6'h00, 6'h22, 0, 0, 4, 1, mk(11'b00000000000, 2'd0, 2'd3, 2'd0, 3'd0)};

    // reset state at time zero, then the directed table back-to-back
    #2;
    chk("init_state", state, S_RST);
    chk("init_outputs", ov, 0);
    do_reset();
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw, tbl[i].ck, lat, v);
      chk({tbl[i].name, "_lat"}, lat, tbl[i].lat);
      chk({tbl[i].name, "_vec"}, v, tbl[i].ev);
    end

    // FETCH stall exhausts the wait budget
    do_reset();
    opcode = 6'h23;
    expect_timeout(S_FETCH);
    step(1'b1);
    chk("halt_sticky", state, S_HALT);
    chk("halt_fault", fault, 2);
    chk("halt_outputs", ov, 0);

    // ready arriving on the last allowed wait cycle completes the fetch
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(1'b0);
      chk("edge_wait", state, S_FETCH);
    end
    step(1'b1);
    chk("edge_irwrite", IRWrite, 1);
    step(1'b1);
    chk("edge_decode", state, S_DECODE);
    chk("edge_nofault", fault, 0);

    // store stall exhausts the wait budget
    do_reset();
    opcode = 6'h2b;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("sw_memadr", state, S_MEMADR);
    expect_timeout(S_MEMWR);

    // illegal opcode
    do_reset();
    opcode = 6'h3f;
    step(1'b1);
    step(1'b1);
    chk("ill_decode", state, S_DECODE);
    step(1'b1);
    chk("ill_state", state, S_HALT);
    chk("ill_fault", fault, 1);
    step(1'b0);
    chk("ill_sticky", fault, 1);

    // asynchronous reset mid-access, then a clean restart
    do_reset();
    opcode = 6'h23;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("mid_memrd", state, S_MEMRD);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_state", state, S_RST);
    chk("mid_rst_outputs", ov, 0);
    chk("mid_rst_fault", fault, 0);
    @(negedge clock);
    reset = 1'b0;
    run_instr(6'h08, 6'h00, 0, 0, -1, lat, v);
    chk("after_rst_lat", lat, 4);

    // random legal instruction streams with random memory stalls
    do_reset();
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 13);
      fn  = 6'($urandom_range(0, 63));
      if (idx == 3) fn = 6'h08;
      else if (ops[idx] == 6'h00 && fn == 6'h08) fn = 6'h20;
      run_instr(ops[idx], fn, $urandom_range(0, 4), $urandom_range(0, 4), -1, lat, v);
      chk("rand_lat", lat, exp_st.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles spent waiting for mem_ready in one memory state.
REQ-002 clock  in  1  processor clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset, asynchronous and active-high.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register.
REQ-005 funct  in  6  instruction[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  unified memory has completed the current access.
REQ-008 Outputs, all 1 bit: PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, instr_done.
REQ-009 Outputs, 2 bits each:
- RegDst: 0 rt, 1 rd, 2 $31.
- ALUSrcB: 0 regB, 1 const 4, 2 imm, 3 imm<<2.
- PCSource: 0 ALU, 1 ALUOut, 2 jump address, 3 regA.
- fault: 0 none, 1 illegal opcode, 2 memory timeout.
REQ-010 Outputs ALUOp (3 bits) and state (4 bits, current state encoding).

Function
REQ-011 Moore FSM with these encodings: RESET_WAIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, RWB=8, BRANCH=9, JUMP=10, JAL=11, JR=12, EXEC_I=13, IWB=14, HALT=15.
REQ-012 Every output not listed for a state SHALL be 0.
REQ-013 RESET_WAIT: all outputs 0; next state FETCH.
REQ-014 FETCH:
- MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=000, PCSource=0.
- IRWrite=PCWrite=mem_ready.
- Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
REQ-015 DECODE:
- ALUSrcA=0, ALUSrcB=3, ALUOp=000.
- Next state by opcode: 100011/101011→MEMADR; 000000 with funct 001000→JR; other 000000→EXEC_R; 000100/000101→BRANCH; 000010→JUMP; 000011→JAL; 001000/001100/001101/001110/001010/001111→EXEC_I; anything else→HALT with fault=1.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=000; next MEMRD if opcode=100011, else MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1; holds until mem_ready=1, then goes to MEMWB.
REQ-018 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1; next FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; holds until mem_ready=1; instr_done=mem_ready; then FETCH.
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=010; next RWB.
REQ-021 RWB: RegDst=1, RegWrite=1, instr_done=1; next FETCH.
REQ-022 BRANCH:
- ALUSrcA=1, ALUSrcB=0, ALUOp=001, PCSource=1, instr_done=1; next FETCH.
- PCWriteCond=1 when opcode=000100; PCWriteCondNe=1 when opcode=000101.
- zero is not combined internally; the datapath gates the PC write.
REQ-023 JUMP: PCWrite=1, PCSource=2, instr_done=1; next FETCH.
REQ-024 JAL: PCWrite=1, PCSource=2, RegDst=2, RegWrite=1, instr_done=1; next FETCH.
REQ-025 JR: PCWrite=1, PCSource=3, instr_done=1; RegWrite=0; next FETCH.
REQ-026 EXEC_I: ALUSrcA=1, ALUSrcB=2; ALUOp by opcode: addi 000, andi 011, ori 100, xori 101, slti 110, lui 111; next IWB.
REQ-027 IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH.
REQ-028 Wait counter:
- Clears on entry to FETCH, MEMRD or MEMWR.
- Increments each cycle spent in one of those states with mem_ready=0.
- When it reaches TIMEOUT with mem_ready still 0: next state HALT, fault=2.
- mem_ready=1 in the same cycle as the count reaching TIMEOUT completes the access; no fault.
REQ-029 HALT: all control outputs 0; fault is held; the state is left only by reset.
REQ-030 fault is registered and changes only on entry to HALT or on reset.
REQ-031 instr_done is asserted for exactly one cycle per retired instruction.
REQ-032 Latencies (cycles, zero-wait memory):
- lw 5; sw 4; R-type 4; addi/andi/ori/xori/slti/lui 4.
- beq/bne 3; j, jal, jr 3.
- Each memory wait cycle adds 1.

Reset
REQ-033 Asserting reset at any time, including mid-instruction or during a memory wait, forces state=0, fault=0, wait counter=0 and all outputs to 0 immediately, without waiting for a clock edge.
REQ-034 After reset deasserts, the first rising edge enters FETCH.
REQ-035 No partial instruction is resumed after reset.

Verification
REQ-036 lw (opcode 100011) with mem_ready tied 1 -> state sequence 1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in state 5; instr_done pulses once.
REQ-037 beq (000100), then bne (000101) -> in state 9: PCWriteCond=1, PCWriteCondNe=0, PCSource=1 for beq; the opposite pair for bne; 3 cycles each.
REQ-038 jr (opcode 0, funct 001000) -> state 12 with PCSource=3, PCWrite=1, RegWrite=0; jal -> state 11 with RegDst=2, RegWrite=1.
REQ-039 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held for 4 cycles; instr_done on the 4th; total latency 7 cycles.
REQ-040 mem_ready held 0 in FETCH with TIMEOUT=16 -> state=15 and fault=2 after 16 wait cycles; opcode 111111 -> state 15, fault=1.
REQ-041 reset pulsed during MEMRD -> state=0 and all outputs 0 before the next edge; after release the sequence 1,2,... resumes cleanly.
